// File: rtl/bitcnt_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : bitcnt_arbiter
//  Purpose  : Shares one bit-counter datapath between N_REQ requesters.
//             Picks a winner round-robin and captures its operand. It then
//             sequences the datapath (load, shift/increment until A == 0)
//             and returns the ones-count with a one-cycle done pulse.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//   clk        in   1              clock, all state on posedge
//   reset      in   1              asynchronous, active-high
//   req        in   N_REQ          job request per requester
//   data       in   N_REQ*WIDTH    operand i at data[i*WIDTH +: WIDTH]
//   gnt        out  N_REQ          one-hot pulse: operand captured this cycle
//   done       out  N_REQ          one-hot pulse: result valid for owner
//   res_out    out  RES_W          ones-count (valid with done, else held)
//   owner      out  log2(N_REQ)    current / last job owner
//   busy       out  1              high in LOAD / COUNT / DONE
//   dp_A       out  WIDTH          captured operand to the datapath
//   dp_load    out  1              datapath load strobe
//   dp_inc     out  1              datapath result increment
//   dp_shift   out  1              datapath A right-shift
//   dp_Ais0    in   1              datapath A == 0
//   dp_a0      in   1              datapath A LSB
//   dp_result  in   RES_W          datapath result register
// ----------------------------------------------------------------------------
//  Configuration macro
//   BITCNT_FIXED_PRIO_EN : fixed priority (lowest index wins), pointer held 0.
//                          Undefined (default): round-robin arbitration.
// ============================================================================
module bitcnt_arbiter #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 8,
   parameter int RES_W = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [N_REQ-1:0]           req,
   input  logic [N_REQ*WIDTH-1:0]     data,
   output logic [N_REQ-1:0]           gnt,
   output logic [N_REQ-1:0]           done,
   output logic [RES_W-1:0]           res_out,
   output logic [$clog2(N_REQ)-1:0]   owner,
   output logic                       busy,
   output logic [WIDTH-1:0]           dp_A,
   output logic                       dp_load,
   output logic                       dp_inc,
   output logic                       dp_shift,
   input  logic                       dp_Ais0,
   input  logic                       dp_a0,
   input  logic [RES_W-1:0]           dp_result
);

   localparam int ID_W = $clog2(N_REQ);

   localparam logic [1:0] c_st_idle  = 2'd0;
   localparam logic [1:0] c_st_load  = 2'd1;
   localparam logic [1:0] c_st_count = 2'd2;
   localparam logic [1:0] c_st_done  = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [ID_W-1:0]  ptr_q,   ptr_d;
   logic [ID_W-1:0]  owner_q, owner_d;
   logic [WIDTH-1:0] dpA_q,   dpA_d;
   logic [RES_W-1:0] res_q,   res_d;

   logic             w_found;
   logic [ID_W-1:0]  w_win;
   logic [ID_W-1:0]  w_ptr_next;

   // Scan requests starting at the pointer, wrapping at N_REQ; first hit wins.
   // In fixed-priority builds the pointer stays 0, so the scan starts at index 0.
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (!w_found && req[(int'(ptr_q) + k) % N_REQ]) begin
            w_found = 1'b1;
            w_win   = ID_W'((int'(ptr_q) + k) % N_REQ);
         end
      end
   end

   assign w_ptr_next = (owner_q == ID_W'(N_REQ - 1)) ? '0 : owner_q + ID_W'(1);

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= c_st_idle;
         ptr_q   <= '0;
         owner_q <= '0;
         dpA_q   <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         dpA_q   <= dpA_d;
         res_q   <= res_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      owner_d = owner_q;
      dpA_d   = dpA_q;
      res_d   = res_q;
      case (state_q)
         c_st_idle: begin
            if (w_found) begin
               state_d = c_st_load;
               owner_d = w_win;
               dpA_d   = data[int'(w_win)*WIDTH +: WIDTH];
            end
         end
         c_st_load:  state_d = c_st_count;
         c_st_count: if (dp_Ais0) state_d = c_st_done;
         c_st_done: begin
            state_d = c_st_idle;
            res_d   = dp_result;
            ptr_d   = w_ptr_next;
         end
         default:    state_d = c_st_idle;
      endcase
`ifdef BITCNT_FIXED_PRIO_EN
      ptr_d = '0;
`endif
   end

   // Output decode. gnt depends on req in IDLE; it is masked during reset
   // because the state register sits in IDLE while reset is held.
   always_comb begin
      gnt      = '0;
      done     = '0;
      busy     = (state_q != c_st_idle);
      dp_load  = (state_q == c_st_load);
      dp_shift = (state_q == c_st_count) && !dp_Ais0;
      dp_inc   = (state_q == c_st_count) && !dp_Ais0 && dp_a0;
      res_out  = (state_q == c_st_done) ? dp_result : res_q;
      owner    = owner_q;
      dp_A     = dpA_q;
      for (int k = 0; k < N_REQ; k++) begin
         gnt[k]  = (state_q == c_st_idle) && !reset && w_found && (w_win == ID_W'(k));
         done[k] = (state_q == c_st_done) && (owner_q == ID_W'(k));
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_bitcnt_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bitcnt_arbiter
//  Purpose  : Self-checking bench for bitcnt_arbiter with a simple counter
//             datapath attached and a job-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bitcnt_arbiter;

   localparam int N_REQ = 4;
   localparam int WIDTH = 8;
   localparam int RES_W = 4;
   localparam int ID_W  = 2;

   logic                   clk = 1'b0;
   logic                   reset;
   logic [N_REQ-1:0]       req;
   logic [N_REQ*WIDTH-1:0] data;
   logic [N_REQ-1:0]       gnt, done;
   logic [RES_W-1:0]       res_out;
   logic [ID_W-1:0]        owner;
   logic                   busy;
   logic [WIDTH-1:0]       dp_A;
   logic                   dp_load, dp_inc, dp_shift;
   logic                   dp_Ais0, dp_a0;
   logic [RES_W-1:0]       dp_result;

   always #5 clk = ~clk;

   bitcnt_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .RES_W(RES_W)) dut (
      .clk(clk), .reset(reset), .req(req), .data(data),
      .gnt(gnt), .done(done), .res_out(res_out), .owner(owner), .busy(busy),
      .dp_A(dp_A), .dp_load(dp_load), .dp_inc(dp_inc), .dp_shift(dp_shift),
      .dp_Ais0(dp_Ais0), .dp_a0(dp_a0), .dp_result(dp_result)
   );

   // Counter datapath attached to the arbiter
   logic [WIDTH-1:0] r_dpa;
   logic [RES_W-1:0] r_dpr;
   always @(posedge clk) begin
      if (dp_load) begin
         r_dpa <= dp_A;
         r_dpr <= '0;
      end else begin
         if (dp_shift) r_dpa <= r_dpa >> 1;
         if (dp_inc)   r_dpr <= r_dpr + 1'b1;
      end
   end
   assign dp_Ais0   = (r_dpa == '0);
   assign dp_a0     = r_dpa[0];
   assign dp_result = r_dpr;

   int total = 0;
   int bad   = 0;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (time %0t)", tag, act, exp, $time);
      end
   endtask

   // Job-level reference model: a grant starts a job whose length depends
   // only on the operand's highest set bit.
   int              cyc;
   int              m_free_at, m_gnt_at, m_done_at, m_p;
   int              m_ptr, m_owner, m_cnt, m_res;
   logic [WIDTH-1:0] m_A;

   function automatic int msb_plus1(input logic [WIDTH-1:0] v);
      int p = 0;
      for (int i = 0; i < WIDTH; i++) if (v[i]) p = i + 1;
      return p;
   endfunction

   task automatic tick();
      logic [N_REQ-1:0] e_gnt, e_done;
      logic             e_busy, e_load, e_shift;
      int               w, base;
      @(negedge clk);
      e_gnt = '0; e_done = '0; e_load = 1'b0; e_shift = 1'b0; w = -1;
      if (cyc >= m_free_at) begin
         e_busy = 1'b0;
`ifdef BITCNT_FIXED_PRIO_EN
         base = 0;
`else
         base = m_ptr;
`endif
         for (int k = 0; k < N_REQ; k++)
            if (w < 0 && req[(base + k) % N_REQ]) w = (base + k) % N_REQ;
         if (w >= 0) e_gnt[w] = 1'b1;
      end else begin
         e_busy  = 1'b1;
         e_load  = (cyc == m_gnt_at + 1);
         e_shift = (cyc >= m_gnt_at + 2) && (cyc <= m_gnt_at + 1 + m_p);
         if (cyc == m_done_at) begin
            e_done[m_owner] = 1'b1;
            m_res = m_cnt;
         end
      end
      check_val("gnt",      32'(gnt),      32'(e_gnt));
      check_val("done",     32'(done),     32'(e_done));
      check_val("busy",     32'(busy),     32'(e_busy));
      check_val("dp_load",  32'(dp_load),  32'(e_load));
      check_val("dp_shift", 32'(dp_shift), 32'(e_shift));
      check_val("inc_load", 32'(dp_inc & dp_load), 32'd0);
      check_val("res_out",  32'(res_out),  32'(m_res));
      check_val("owner",    32'(owner),    32'(m_owner));
      check_val("dp_A",     32'(dp_A),     32'(m_A));
      if (w >= 0) begin
         m_owner   = w;
         m_A       = data[w*WIDTH +: WIDTH];
         m_cnt     = $countones(m_A);
         m_p       = msb_plus1(m_A);
         m_gnt_at  = cyc;
         m_done_at = cyc + 3 + m_p;
         m_free_at = cyc + 4 + m_p;
      end
      if (e_done != '0) begin
`ifdef BITCNT_FIXED_PRIO_EN
         m_ptr = 0;
`else
         m_ptr = (m_owner + 1) % N_REQ;
`endif
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Asserts reset between edges, checks the asynchronous clear, releases
   // after one clock edge.
   task automatic do_reset();
      reset = 1'b1;
      #1;
      check_val("rst_busy",  32'(busy),    32'd0);
      check_val("rst_done",  32'(done),    32'd0);
      check_val("rst_gnt",   32'(gnt),     32'd0);
      check_val("rst_load",  32'(dp_load | dp_inc | dp_shift), 32'd0);
      check_val("rst_owner", 32'(owner),   32'd0);
      check_val("rst_dpA",   32'(dp_A),    32'd0);
      check_val("rst_res",   32'(res_out), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      cyc++;
      m_free_at = cyc; m_gnt_at = -100; m_done_at = -100; m_p = 0;
      m_ptr = 0; m_owner = 0; m_A = '0; m_res = 0; m_cnt = 0;
   endtask

   initial begin
      reset = 1'b1; req = '0; data = '0; cyc = 0;
      do_reset();
      repeat (5) tick();

      // single job, operand 0xAA
      data[0*WIDTH +: WIDTH] = 8'hAA; req = 4'b0001;
      tick(); req = '0;
      repeat (12) tick();

      // zero operand then all-ones operand on requester 2
      data[2*WIDTH +: WIDTH] = 8'h00; req = 4'b0100;
      tick(); req = '0;
      repeat (5) tick();
      data[2*WIDTH +: WIDTH] = 8'hFF; req = 4'b0100;
      tick(); req = '0;
      repeat (12) tick();

      // all requesting with the same operand: rotation
      data = {4{8'h05}}; req = 4'b1111;
      repeat (40) tick();
      req = '0;
      repeat (8) tick();

      // reset in the middle of a job
      data[0*WIDTH +: WIDTH] = 8'hAA; req = 4'b0001;
      tick(); req = '0;
      repeat (4) tick();
      req = 4'b0010; data[1*WIDTH +: WIDTH] = 8'h3C;
      do_reset();
      tick(); req = '0;
      repeat (10) tick();

      // owner drops req and changes data after the grant
      data[3*WIDTH +: WIDTH] = 8'h96; req = 4'b1000;
      tick(); tick();
      req = '0; data[3*WIDTH +: WIDTH] = 8'hFF;
      repeat (12) tick();

      // randomized traffic
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 1) == 0) req = 4'($urandom_range(0, 15));
         for (int i = 0; i < N_REQ; i++)
            if ($urandom_range(0, 3) == 0)
               data[i*WIDTH +: WIDTH] = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
         if ($urandom_range(0, 249) == 0) do_reset();
         else tick();
      end
      req = '0;
      repeat (14) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
